// File: rtl/revenantx86_tinytpu.sv
// 2x2 signed int8 matrix-multiply accelerator (C = A x W) behind the TinyTapeout byte port.
// Define TINYTPU_RELU_EN to clamp each saturated result to max(C,0).
module revenantx86_tinytpu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic signed [7:0] w_q [4];
  logic signed [7:0] a_q [4];
  logic [15:0]       c_all [4];
  logic [3:0]        ovf;
  logic [1:0]        wptr_q, aptr_q;
  logic [2:0]        rptr_q, cnt_q;
  logic              sat_q;
  logic [7:0]        uo_q;

  logic       strobe, running, accept, step, fin;
  logic       do_clear, do_lw, do_la, do_cmp, do_rd;
  logic [2:0] code;
  logic       unused_hi;

  function automatic logic [15:0] sat16(input logic signed [16:0] v);
    if (v[16] != v[15]) return v[16] ? 16'h8000 : 16'h7FFF;
    return v[15:0];
  endfunction

  function automatic logic [15:0] relu16(input logic [15:0] v);
`ifdef TINYTPU_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  assign unused_hi = ^uio_in[7:4];
  assign code      = uio_in[2:0];
  assign strobe    = ena & uio_in[3];
  assign running   = (state_q == S_RUN);
  assign accept    = strobe & ~running;
  assign do_clear  = strobe && (code == 3'd5);
  assign do_lw     = accept && (code == 3'd1);
  assign do_la     = accept && (code == 3'd2);
  assign do_cmp    = accept && (code == 3'd3);
  assign do_rd     = accept && (code == 3'd4);
  // Four feed steps (cnt 0..3) followed by one saturate/write-back step (cnt 4).
  assign step      = ena && running && !cnt_q[2] && !do_clear;
  assign fin       = ena && running && (cnt_q == 3'd4) && !do_clear;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (do_cmp) state_d = S_RUN;
      S_RUN:   if (fin) state_d = S_DONE;
      S_DONE: begin
        if (do_cmp)             state_d = S_RUN;
        else if (do_lw || do_la) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (do_clear) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      aptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      uo_q    <= '0;
      for (int k = 0; k < 4; k++) begin
        w_q[k] <= '0;
        a_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (do_clear) begin
        wptr_q <= '0;
        aptr_q <= '0;
        rptr_q <= '0;
        sat_q  <= 1'b0;
        uo_q   <= '0;
      end else begin
        if (do_lw) begin
          w_q[wptr_q] <= ui_in;
          wptr_q      <= wptr_q + 2'd1;
        end
        if (do_la) begin
          a_q[aptr_q] <= ui_in;
          aptr_q      <= aptr_q + 2'd1;
        end
        if (do_cmp) begin
          rptr_q <= '0;
          sat_q  <= 1'b0;
          cnt_q  <= '0;
        end else if (step) begin
          cnt_q <= cnt_q + 3'd1;
        end
        if (fin) sat_q <= |ovf;
        if (do_rd) begin
          uo_q   <= rptr_q[0] ? c_all[rptr_q[2:1]][15:8] : c_all[rptr_q[2:1]][7:0];
          rptr_q <= rptr_q + 3'd1;
        end
      end
    end
  end

  // MAC cell (ROW,COL) sees k = cnt - (ROW+COL): the skew staggers the operand wavefront.
  for (genvar g = 0; g < 4; g++) begin : g_mac
    localparam int ROW = g / 2;
    localparam int COL = g % 2;
    localparam logic [2:0] SKEW = 3'(ROW + COL);

    logic [2:0]         kidx;
    logic               ksel, feed;
    logic signed [7:0]  op_a, op_w;
    logic signed [15:0] prod;
    logic signed [16:0] acc_q;
    logic [15:0]        c_q;

    assign kidx = cnt_q - SKEW;
    assign ksel = kidx[0];
    assign feed = step && (kidx < 3'd2);
    assign op_a = ksel ? a_q[2*ROW+1] : a_q[2*ROW];
    assign op_w = ksel ? w_q[2+COL]   : w_q[COL];
    assign prod = op_a * op_w;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
        c_q   <= '0;
      end else if (do_clear) begin
        acc_q <= '0;
        c_q   <= '0;
      end else if (do_cmp) begin
        acc_q <= '0;
      end else if (feed) begin
        acc_q <= acc_q + 17'(prod);
      end else if (fin) begin
        c_q <= relu16(sat16(acc_q));
      end
    end

    assign ovf[g]   = acc_q[16] ^ acc_q[15];
    assign c_all[g] = c_q;
  end

  assign uo_out  = uo_q;
  assign uio_oe  = 8'hF0;
  assign uio_out = {1'b0, sat_q, (state_q == S_DONE), (running && (cnt_q != 3'd0)), 4'b0000};

endmodule

// File: tb/tb_revenantx86_tinytpu.sv
// Randomized self-checking bench for revenantx86_tinytpu against an arithmetic matmul model.
module tb_revenantx86_tinytpu;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in;
  wire  [7:0] uio_out, uio_oe, uo_out;

  int total = 0;
  int bad   = 0;

  int         mw [4];
  int         ma [4];
  int         mc [4];
  int         wp, ap, rp;
  bit         msat;
  logic [7:0] muo;

  always #5 clk = ~clk;

  revenantx86_tinytpu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .uo_out (uo_out)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] code, input logic [7:0] d);
    ui_in  = d;
    uio_in = {4'h0, 1'b1, code};
    @(posedge clk);
    #1;
    uio_in = 8'h00;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mw[k] = 0;
      ma[k] = 0;
      mc[k] = 0;
    end
    wp = 0; ap = 0; rp = 0; msat = 0; muo = 8'h00;
  endtask

  task automatic load_w(input logic [7:0] d);
    send(3'd1, d);
    mw[wp] = int'($signed(d));
    wp = (wp + 1) % 4;
  endtask

  task automatic load_a(input logic [7:0] d);
    send(3'd2, d);
    ma[ap] = int'($signed(d));
    ap = (ap + 1) % 4;
  endtask

  task automatic model_compute();
    int s;
    msat = 0;
    rp   = 0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = ma[2*i] * mw[j] + ma[2*i+1] * mw[2+j];
        if (s > 32767) begin s = 32767; msat = 1; end
        if (s < -32768) begin s = -32768; msat = 1; end
`ifdef TINYTPU_RELU_EN
        if (s < 0) s = 0;
`endif
        mc[2*i+j] = s;
      end
    end
  endtask

  function automatic logic [7:0] exp_byte(input int idx);
    logic [15:0] v;
    v = 16'(mc[idx / 2]);
    return (idx % 2 == 1) ? v[15:8] : v[7:0];
  endfunction

  task automatic do_read(input string tag);
    send(3'd4, 8'h00);
    muo = exp_byte(rp);
    rp  = (rp + 1) % 8;
    chk(tag, {8'h00, uo_out}, {8'h00, muo});
  endtask

  task automatic read_n(input string tag, input int n);
    for (int k = 0; k < n; k++) do_read(tag);
  endtask

  // When inject is set, LOAD_W, LOAD_A and READ are strobed on the busy edges and must be ignored.
  task automatic compute(input bit inject);
    send(3'd3, 8'h00);
    model_compute();
    for (int t = 1; t <= 4; t++) begin
      if (inject && t >= 2) begin
        ui_in  = 8'h5A;
        uio_in = {4'h0, 1'b1, (t == 2) ? 3'd1 : ((t == 3) ? 3'd2 : 3'd4)};
      end
      @(posedge clk);
      #1;
      uio_in = 8'h00;
      chk("busy_run", {15'b0, uio_out[4]}, 16'd1);
    end
    if (inject) chk("uo_hold_busy", {8'h00, uo_out}, {8'h00, muo});
    tick(1);
    chk("busy_end", {15'b0, uio_out[4]}, 16'd0);
    chk("done_end", {15'b0, uio_out[5]}, 16'd1);
    chk("sat", {15'b0, uio_out[6]}, {15'b0, msat});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    model_reset();
    tick(3);
    chk("rst_uo", {8'h00, uo_out}, 16'h0000);
    chk("rst_uio_out", {8'h00, uio_out}, 16'h0000);
    chk("rst_uio_oe", {8'h00, uio_oe}, 16'h00F0);
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;
    read_n("rst_read", 8);

    load_a(8'd1); load_a(8'd2); load_a(8'd3); load_a(8'd4);
    load_w(8'd5); load_w(8'd6); load_w(8'd7); load_w(8'd8);
    compute(1'b0);
    read_n("basic_read", 8);

    for (int k = 0; k < 4; k++) begin
      load_a(8'h80);
      load_w(8'h80);
    end
    compute(1'b0);
    read_n("sat_read", 8);

    load_a(8'hFF); load_a(8'h00); load_a(8'h00); load_a(8'hFF);
    load_w(8'h01); load_w(8'h00); load_w(8'h00); load_w(8'h01);
    compute(1'b0);
    read_n("neg_read", 8);

    load_w(8'd10); load_w(8'd20); load_w(8'd30); load_w(8'd40); load_w(8'd50);
    load_a(8'd1); load_a(8'd0); load_a(8'd0); load_a(8'd1);
    compute(1'b1);
    read_n("wrap_read", 9);

    ena = 1'b0;
    send(3'd1, 8'h77);
    send(3'd4, 8'h00);
    send(3'd5, 8'h00);
    chk("ena0_uo", {8'h00, uo_out}, {8'h00, muo});
    chk("ena0_done", {15'b0, uio_out[5]}, 16'd1);
    ena = 1'b1;
    compute(1'b0);
    read_n("recompute_read", 8);

    load_w(8'h03);
    chk("load_leaves_done", {15'b0, uio_out[5]}, 16'd0);

    send(3'd3, 8'h00);
    tick(1);
    send(3'd5, 8'h00);
    chk("abort_busy", {15'b0, uio_out[4]}, 16'd0);
    chk("abort_done", {15'b0, uio_out[5]}, 16'd0);
    chk("abort_uo", {8'h00, uo_out}, 16'h0000);
    wp = 0; ap = 0; rp = 0; msat = 0; muo = 8'h00;
    for (int k = 0; k < 4; k++) mc[k] = 0;
    read_n("abort_read", 8);
    compute(1'b0);
    read_n("retained_read", 8);

    for (int it = 0; it < 8; it++) begin
      int nl;
      nl = $urandom_range(4, 6);
      for (int k = 0; k < nl; k++) begin
        load_a(8'($urandom));
        load_w(8'($urandom));
      end
      compute(it[0]);
      read_n("rand_read", $urandom_range(6, 10));
    end

    send(3'd3, 8'h00);
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_uo", {8'h00, uo_out}, 16'h0000);
    chk("midrst_uio_out", {8'h00, uio_out}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    read_n("midrst_read", 8);
    compute(1'b0);
    read_n("zero_mat_read", 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
